// File: rtl/eth_switch_pkg.sv
// Shared types and sizing constants for the Ethernet switch datapath blocks.
// The egress arbiter and the fabric scheduler both pull their defaults from here.
package eth_switch_pkg;

  localparam int NUM_OF_PORTS       = 4;
  localparam int RXTX_DATA_SIZE     = 32;
  localparam int RXTXCTRL_BITS_SIZE = 4;
  localparam int FIFO_DEPTH         = 2048;
  localparam int IFG_CYC            = 3;
  localparam int ARB_TIMEOUT        = FIFO_DEPTH;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_GAP} ARB_STATE_t;

  // Width of a counter that must hold 0..max_val without wrapping (never 0 bits).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
// Kept standalone so the fabric scheduler can share it.
module rr_picker
  import eth_switch_pkg::*;
#(
  parameter int N  = NUM_OF_PORTS,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          pick_valid
);

  // One spare bit so rr_ptr + k never overflows before the explicit wrap.
  logic [PW:0] pos;

  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    pos        = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, rr_ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!pick_valid && req[pos[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = pos[PW-1:0];
      end
    end
    if (pick_valid) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/eth_out_arbiter.sv
// Per-egress-port packet scheduler: packet-granular round-robin over NUM_PORTS queues,
// with an inter-frame gap after every packet and a stall watchdog that truncates dead packets.
module eth_out_arbiter
  import eth_switch_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_OF_PORTS,
  parameter int DATA_W      = RXTX_DATA_SIZE,
  parameter int CTRL_W      = RXTXCTRL_BITS_SIZE,
  parameter int IFG_CYC     = eth_switch_pkg::IFG_CYC,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS-1:0]        in_last,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS*CTRL_W-1:0] in_ctrl,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [DATA_W-1:0]           out_data,
  output logic [CTRL_W-1:0]           out_ctrl,
  input  logic                        out_ready,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic                        busy,
  output logic                        abort
);

  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IW       = cnt_width(IFG_CYC);
  localparam int WW       = cnt_width(TIMEOUT_CYC - 1);
  localparam int IFG_LOAD = (IFG_CYC > 0) ? IFG_CYC - 1 : 0;
  localparam int WD_MAX   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  ARB_STATE_t state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        ifg_q, ifg_d;
  logic [WW-1:0]        wd_q, wd_d;

  logic [NUM_PORTS-1:0] pick;
  logic [PW-1:0]        pick_idx;
  logic                 pick_valid;

  logic                 send_st;
  logic                 sel_valid, sel_last;
  logic [DATA_W-1:0]    sel_data;
  logic [CTRL_W-1:0]    sel_ctrl;
  logic                 xfer, timeout, release_pkt;
  logic [PW-1:0]        rr_next;

  rr_picker #(.N(NUM_PORTS), .PW(PW)) u_picker (
    .req        (req),
    .rr_ptr     (rr_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      ifg_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      ifg_q   <= ifg_d;
      wd_q    <= wd_d;
    end
  end

  // AND-OR mux on the one-hot grant; yields all zeros whenever nothing is granted.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_ctrl  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_q[i]) begin
        sel_valid = sel_valid | in_valid[i];
        sel_last  = sel_last  | in_last[i];
        sel_data  = sel_data  | in_data[i*DATA_W +: DATA_W];
        sel_ctrl  = sel_ctrl  | in_ctrl[i*CTRL_W +: CTRL_W];
      end
    end
  end

  assign send_st     = (state_q == ARB_SEND);
  assign xfer        = send_st & sel_valid & out_ready;
  assign timeout     = send_st & ~sel_valid & (wd_q == WW'(WD_MAX));
  assign release_pkt = (xfer & sel_last) | timeout;
  assign rr_next     = (idx_q == PW'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_valid) state_d = ARB_SEND;
      ARB_SEND: if (release_pkt) state_d = (IFG_CYC == 0) ? ARB_IDLE : ARB_GAP;
      ARB_GAP:  if (ifg_q == '0) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    rr_d  = rr_q;
    ifg_d = ifg_q;
    wd_d  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d = pick;
          idx_d = pick_idx;
        end
      end
      ARB_SEND: begin
        if (release_pkt) begin
          gnt_d = '0;
          rr_d  = rr_next;
          ifg_d = IW'(IFG_LOAD);
        end else if (!sel_valid) begin
          // Only cycles with no beat offered count; backpressure from out_ready does not.
          wd_d = (wd_q == WW'(WD_MAX)) ? wd_q : wd_q + 1'b1;
        end
      end
      ARB_GAP: begin
        if (ifg_q != '0) ifg_d = ifg_q - 1'b1;
      end
      default: gnt_d = '0;
    endcase
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != ARB_IDLE);
  assign abort     = timeout;
  assign out_valid = send_st & sel_valid;
  assign out_last  = send_st & sel_valid & sel_last;
  assign out_data  = sel_data;
  assign out_ctrl  = sel_ctrl;
  assign in_ready  = gnt_q & {NUM_PORTS{out_ready & send_st}};

endmodule

// File: tb/tb_eth_out_arbiter.sv
// Bench for eth_out_arbiter: scripted vector table, hand-written corner sequences and
// randomized traffic, all checked cycle by cycle against a behavioural scheduler model.
module tb_eth_out_arbiter;
  import eth_switch_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int IFG = 3;
  localparam int TO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] req, in_valid, in_last, in_ready, gnt;
  logic [N*DW-1:0] in_data;
  logic [N*CW-1:0] in_ctrl;
  logic out_valid, out_last, out_ready, busy, abort;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;

  logic [N-1:0] b_req, b_in_valid, b_in_last, b_in_ready, b_gnt;
  logic [N*DW-1:0] b_in_data;
  logic [N*CW-1:0] b_in_ctrl;
  logic b_out_valid, b_out_last, b_out_ready, b_busy, b_abort;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;

  eth_out_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .CTRL_W(CW), .IFG_CYC(IFG), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_ready(in_ready), .out_valid(out_valid),
    .out_last(out_last), .out_data(out_data), .out_ctrl(out_ctrl), .out_ready(out_ready),
    .gnt(gnt), .busy(busy), .abort(abort)
  );

  eth_out_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .CTRL_W(CW), .IFG_CYC(0), .TIMEOUT_CYC(TO)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .req(b_req), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_data(b_out_data), .out_ctrl(b_out_ctrl), .out_ready(b_out_ready),
    .gnt(b_gnt), .busy(b_busy), .abort(b_abort)
  );

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          abort;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } obs_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] req, vld, lst;
    logic         ordy;
    logic [N-1:0] e_gnt;
    logic         e_valid, e_last, e_busy;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc_no  = 0;
  obs_t s_obs, b_obs, exp_obs;

  // Scheduler model: owner = port holding the grant (-1 none), gap = idle cycles still owed.
  int m_owner, m_gap, m_ptr, m_wd;

  task automatic m_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_wd = 0;
  endtask

  function automatic obs_t model_expect();
    obs_t e;
    e = '0;
    if (!rst_n) return e;
    if (m_owner >= 0) begin
      e.gnt       = N'(1) << m_owner;
      e.in_ready  = out_ready ? (N'(1) << m_owner) : '0;
      e.out_valid = in_valid[m_owner];
      e.out_last  = in_valid[m_owner] & in_last[m_owner];
      e.abort     = !in_valid[m_owner] && (m_wd == TO - 1);
      e.data      = in_data[m_owner*DW +: DW];
      e.ctrl      = in_ctrl[m_owner*CW +: CW];
    end
    e.busy = (m_owner >= 0) || (m_gap > 0);
    return e;
  endfunction

  task automatic model_step();
    int p;
    if (m_owner >= 0) begin
      if ((in_valid[m_owner] && out_ready && in_last[m_owner]) ||
          (!in_valid[m_owner] && m_wd == TO - 1)) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = IFG; m_wd = 0;
      end else begin
        m_wd = in_valid[m_owner] ? 0 : m_wd + 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (m_owner < 0 && req[p]) m_owner = p;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s @cyc%0d: got %0h, expected %0h", name, cyc_no, got, want);
    end
  endtask

  // One clock: sample at the falling edge, compare with the model, advance it, then step past the rise.
  task automatic cycle();
    @(negedge clk);
    s_obs = {gnt, in_ready, out_valid, out_last, busy, abort, out_data, out_ctrl};
    b_obs = {b_gnt, b_in_ready, b_out_valid, b_out_last, b_busy, b_abort, b_out_data, b_out_ctrl};
    exp_obs = model_expect();
    vec_cnt++;
    if (s_obs !== exp_obs) begin
      err_cnt++;
      $display("FAIL model @cyc%0d: got gnt=%b rdy=%b v=%b l=%b busy=%b ab=%b d=%h c=%h; expected gnt=%b rdy=%b v=%b l=%b busy=%b ab=%b d=%h c=%h",
               cyc_no, s_obs.gnt, s_obs.in_ready, s_obs.out_valid, s_obs.out_last, s_obs.busy,
               s_obs.abort, s_obs.data, s_obs.ctrl, exp_obs.gnt, exp_obs.in_ready, exp_obs.out_valid,
               exp_obs.out_last, exp_obs.busy, exp_obs.abort, exp_obs.data, exp_obs.ctrl);
    end
    model_step();
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    b_req = '0; b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_gnt", 64'(gnt), 64'(0));
    chk("reset_outs", 64'({out_valid, out_last, busy, abort, in_ready, out_data}), 64'(0));
    chk("reset_nogap", 64'({b_gnt, b_out_valid, b_busy, b_in_ready}), 64'(0));
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Invariants that must hold on every cycle regardless of stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt) && $onehot0(b_gnt)) else begin
        err_cnt++; $display("FAIL inv_gnt_onehot: gnt=%b nogap_gnt=%b", gnt, b_gnt);
      end
      assert (!(out_valid && gnt == '0)) else begin
        err_cnt++; $display("FAIL inv_valid_outside_send: out_valid=%b gnt=%b", out_valid, gnt);
      end
      assert ($onehot0(in_ready) && $onehot0(b_in_ready)) else begin
        err_cnt++; $display("FAIL inv_ready_onehot: in_ready=%b nogap=%b", in_ready, b_in_ready);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  vec_t tbl[$];
  logic [DW-1:0] got_beats[$];

  function automatic vec_t mkv(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] v,
                               input logic [N-1:0] l, input logic eg_v, input logic [N-1:0] eg,
                               input logic ev, input logic el, input logic eb);
    vec_t t;
    t.rst = rst; t.req = rq; t.vld = v; t.lst = l; t.ordy = 1'b1;
    t.e_gnt = eg; t.e_valid = ev; t.e_last = el; t.e_busy = eb;
    if (!eg_v) t.e_gnt = '0;
    return t;
  endfunction

  initial begin
    int b, n, ph, g, pv;
    clear_inputs();
    in_data = '0; in_ctrl = '0; b_in_data = '0; b_in_ctrl = '0;
    #2;

    // Scenario: port2 sends 5 beats, then 3 gap cycles, idle, and the pointer sits at port3.
    tbl.push_back(mkv(1, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 1));
    tbl.push_back(mkv(0, 4'b0100, 4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mkv(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mkv(0, 4'b1111, 4'b1000, 4'b1000, 1, 4'b1000, 1, 1, 1));
    // Scenario: all ports request 1-beat packets; grants 0,1,2,3,0 spaced 5 cycles.
    for (int c = 0; c < 22; c++) begin
      ph = c % 5;
      g  = (c / 5) % 4;
      tbl.push_back(mkv(c == 0, 4'b1111, 4'b1111, 4'b1111, ph == 1, N'(1) << g,
                        ph == 1, ph == 1, ph != 0));
    end

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req = tbl[i].req; in_valid = tbl[i].vld; in_last = tbl[i].lst; out_ready = tbl[i].ordy;
      for (int p = 0; p < N; p++) in_data[p*DW +: DW] = {8'(p), 24'(i)};
      cycle();
      vec_cnt++;
      if (s_obs.gnt !== tbl[i].e_gnt || s_obs.out_valid !== tbl[i].e_valid ||
          s_obs.out_last !== tbl[i].e_last || s_obs.busy !== tbl[i].e_busy) begin
        err_cnt++;
        $display("FAIL tbl[%0d]: got gnt=%b v=%b l=%b busy=%b, expected gnt=%b v=%b l=%b busy=%b",
                 i, s_obs.gnt, s_obs.out_valid, s_obs.out_last, s_obs.busy,
                 tbl[i].e_gnt, tbl[i].e_valid, tbl[i].e_last, tbl[i].e_busy);
      end
    end
    clear_inputs();

    // Backpressure: 10 stalled cycles mid-packet must neither lose nor repeat a beat.
    do_reset();
    req = 4'b0001;
    b = 0;
    for (int c = 0; c < 40 && b < 8; c++) begin
      in_valid[0] = 1'b1;
      in_last[0]  = (b == 7);
      in_data[DW-1:0] = 32'hA000 + 32'(b);
      out_ready = !(c >= 4 && c < 14);
      cycle();
      if (!out_ready) chk("stall_in_ready", 64'(s_obs.in_ready), 64'(0));
      chk("stall_abort", 64'(s_obs.abort), 64'(0));
      if (s_obs.out_valid && out_ready) got_beats.push_back(s_obs.data);
      if (s_obs.in_ready[0]) b++;
    end
    chk("stall_beats_sent", 64'(b), 64'(8));
    chk("stall_beats_seen", 64'(got_beats.size()), 64'(8));
    foreach (got_beats[k]) chk("stall_beat_data", 64'(got_beats[k]), 64'(32'hA000 + 32'(k)));
    clear_inputs();
    repeat (4) cycle();

    // Watchdog: port1 goes silent after 2 beats; abort 16 cycles later, then port3 after the gap.
    do_reset();
    req = 4'b0010;
    cycle();
    in_valid = 4'b0010;
    cycle();
    chk("wd_beat1", 64'(s_obs.out_valid), 64'(1));
    cycle();
    chk("wd_beat2", 64'(s_obs.out_valid), 64'(1));
    in_valid = '0; req = 4'b1010;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      n++;
      if (s_obs.abort) break;
    end
    chk("wd_abort_latency", 64'(n), 64'(TO));
    cycle();
    chk("wd_abort_pulse", 64'({s_obs.abort, s_obs.gnt}), 64'(0));
    cycle(); cycle(); cycle();
    chk("wd_idle_gnt", 64'(s_obs.gnt), 64'(0));
    cycle();
    chk("wd_next_grant", 64'(s_obs.gnt), 64'(4'b1000));
    in_valid = 4'b1000; in_last = 4'b1000;
    cycle();
    clear_inputs();
    repeat (4) cycle();

    // Asynchronous reset in the middle of beat 3 of 8 clears outputs before the next edge.
    do_reset();
    req = 4'b0001;
    cycle();
    in_valid = 4'b0001;
    cycle(); cycle();
    in_data[DW-1:0] = 32'hB003;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 64'(gnt), 64'(0));
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_ready", 64'(in_ready), 64'(0));
    m_reset();
    clear_inputs();
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    cycle();
    cycle();
    chk("rst_first_grant", 64'(s_obs.gnt), 64'(4'b0001));
    in_valid = 4'b1111; in_last = 4'b1111;
    cycle();
    clear_inputs();
    repeat (4) cycle();

    // A request arriving with the last beat waits out the gap (3) plus one idle cycle.
    do_reset();
    req = 4'b0010;
    cycle();
    in_valid = 4'b0010;
    cycle();
    in_last = 4'b0010; req = 4'b0110;
    cycle();
    chk("gap_last_beat", 64'(s_obs.out_last), 64'(1));
    in_valid = '0; in_last = '0; req = 4'b0100;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      n++;
      if (s_obs.gnt[2]) break;
    end
    chk("gap_grant_delay", 64'(n), 64'(IFG + 2));
    in_valid = 4'b0100; in_last = 4'b0100;
    cycle();
    clear_inputs();

    // Same situation with IFG_CYC=0: grant follows directly after one idle cycle.
    do_reset();
    b_req = 4'b0010;
    cycle();
    b_in_valid = 4'b0010; b_in_last = 4'b0010; b_req = 4'b0110;
    cycle();
    chk("nogap_last", 64'({b_obs.gnt, b_obs.out_last}), 64'({4'b0010, 1'b1}));
    b_in_valid = '0; b_in_last = '0; b_req = 4'b0100;
    cycle();
    chk("nogap_idle", 64'({b_obs.gnt, b_obs.busy}), 64'(0));
    cycle();
    chk("nogap_grant", 64'(b_obs.gnt), 64'(4'b0100));
    b_in_valid = 4'b0100; b_in_last = 4'b0100;
    cycle();
    clear_inputs();

    // Randomized traffic; the sparse-valid phase drives many watchdog aborts.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      case ((c / 250) % 3)
        0:       pv = 50;
        1:       pv = 6;
        default: pv = 90;
      endcase
      req = N'($urandom);
      for (int p = 0; p < N; p++) begin
        in_valid[p] = ($urandom_range(99) < pv);
        in_last[p]  = ($urandom_range(99) < 25);
        in_data[p*DW +: DW] = $urandom;
        in_ctrl[p*CW +: CW] = CW'($urandom);
      end
      out_ready = ($urandom_range(99) < 75);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
